// File: rtl/diff_key_loader.sv
// Key loader for the diff core: assembles streamed 32-bit words into a shadow key,
// commits it atomically and gates ap_start. Optional checksum word: `define KEY_CHECKSUM_EN.
module diff_key_loader #(
    parameter int KEY_W   = 3071,
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 96,
    parameter int CNT_W   = 7
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              load_req,
    input  logic              load_abort,
    input  logic              core_idle,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_valid,
    output logic              busy,
    output logic              err,
    input  logic              core_start_in,
    output logic              core_start_out
);

    localparam int EXT_W = N_WORDS * WORD_W;
    localparam int IDX_W = $clog2(EXT_W);

`ifdef KEY_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2, CHECK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;
`endif

    state_t             state, state_nxt;
    logic [KEY_W-1:0]   shadow, shadow_nxt;
    logic [CNT_W-1:0]   counter;
    logic [IDX_W-1:0]   idx;
    logic               last_word;
    logic               accept;
    logic               start_load;

    assign last_word  = (counter == CNT_W'(N_WORDS - 1));
    assign accept     = word_valid & word_ready & ~load_abort;
    assign start_load = load_req & core_idle;
    assign idx        = IDX_W'(counter) * IDX_W'(WORD_W);

    // Each word slot is written exactly once per load, so OR-ing into a cleared shadow suffices;
    // the truncating cast drops key-store bits that fall at or above KEY_W.
    assign shadow_nxt = shadow | KEY_W'(EXT_W'(word_data) << idx);

    assign core_start_out = core_start_in & key_valid & ~busy;

`ifdef KEY_CHECKSUM_EN
    logic [WORD_W-1:0] csum;
    logic              csum_ok;
    assign csum_ok = (word_data == csum);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        word_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, READY: begin
                if (start_load) state_nxt = LOAD;
            end
            LOAD: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (load_abort) begin
                    state_nxt = IDLE;
                end else if (word_valid && last_word) begin
`ifdef KEY_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = READY;
`endif
                end
            end
`ifdef KEY_CHECKSUM_EN
            CHECK: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (load_abort) begin
                    state_nxt = IDLE;
                end else if (word_valid) begin
                    state_nxt = csum_ok ? READY : IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            shadow    <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            counter   <= '0;
`ifdef KEY_CHECKSUM_EN
            csum      <= '0;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, READY: begin
                    if (start_load) begin
                        key_valid <= 1'b0;
                        counter   <= '0;
                        shadow    <= '0;
`ifdef KEY_CHECKSUM_EN
                        csum      <= '0;
                        err       <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        shadow <= '0;
                    end else if (accept) begin
                        shadow  <= shadow_nxt;
                        counter <= counter + CNT_W'(1);
`ifdef KEY_CHECKSUM_EN
                        csum    <= csum ^ word_data;
`else
                        if (last_word) begin
                            key_out   <= shadow_nxt;
                            key_valid <= 1'b1;
                        end
`endif
                    end
                end
`ifdef KEY_CHECKSUM_EN
                CHECK: begin
                    if (load_abort) begin
                        shadow <= '0;
                    end else if (accept) begin
                        counter <= counter + CNT_W'(1);
                        if (csum_ok) begin
                            key_out   <= shadow;
                            key_valid <= 1'b1;
                        end else begin
                            key_out   <= '0;
                            key_valid <= 1'b0;
                            err       <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_diff_key_loader.sv
// Scoreboard bench for diff_key_loader: stimulus pushes expected committed keys,
// a monitor compares on every rising key_valid.
module tb_diff_key_loader;

    localparam int KEY_W   = 3071;
    localparam int WORD_W  = 32;
    localparam int N_WORDS = 96;
    localparam int CNT_W   = 7;
    localparam int EXT_W   = N_WORDS * WORD_W;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              load_req, load_abort, core_idle, word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready, key_valid, busy, err;
    logic [KEY_W-1:0]  key_out;
    logic              core_start_in, core_start_out;

    int errors = 0;
    int checks = 0;
    logic [KEY_W-1:0] exp_q[$];
    logic kv_prev = 1'b0;

    always #5 ap_clk = ~ap_clk;

    diff_key_loader #(.KEY_W(KEY_W), .WORD_W(WORD_W), .N_WORDS(N_WORDS), .CNT_W(CNT_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .load_req(load_req), .load_abort(load_abort),
        .core_idle(core_idle), .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .key_out(key_out), .key_valid(key_valid), .busy(busy),
        .err(err), .core_start_in(core_start_in), .core_start_out(core_start_out)
    );

    function automatic logic [WORD_W-1:0] word_of(input int pat, input int k);
        case (pat)
            0:       return WORD_W'(k);
            1:       return 32'hA5A5A5A5 ^ WORD_W'(k);
            default: return 32'h5A5A0000 | WORD_W'(k);
        endcase
    endfunction

    function automatic logic [KEY_W-1:0] exp_key(input int pat);
        logic [EXT_W-1:0] ext = '0;
        for (int k = 0; k < N_WORDS; k++) ext = {word_of(pat, k), ext[EXT_W-1:WORD_W]};
        return ext[KEY_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] csum_of(input int pat);
        logic [WORD_W-1:0] c = '0;
        for (int k = 0; k < N_WORDS; k++) c = c ^ word_of(pat, k);
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge ap_clk) begin
        if (ap_rst_n && key_valid && !kv_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit: key_valid rose with no key expected, got low word %h", key_out[31:0]);
            end else begin
                logic [KEY_W-1:0] e;
                e = exp_q.pop_front();
                if (key_out !== e) begin
                    errors++;
                    $display("FAIL key_commit: got lo=%h hi=%h expected lo=%h hi=%h",
                             key_out[31:0], key_out[KEY_W-1:KEY_W-31], e[31:0], e[KEY_W-1:KEY_W-31]);
                end
            end
        end
        kv_prev = key_valid;
    end

    task automatic start_load();
        load_req  = 1'b1;
        core_idle = 1'b1;
        @(posedge ap_clk); #1;
        load_req = 1'b0;
        @(negedge ap_clk);
        check("start_busy", busy, 1);
        check("start_key_valid", key_valid, 0);
        @(posedge ap_clk); #1;
    endtask

    // abort_at >= 0: abort together with the handshake of word abort_at+1
    task automatic stream(input int pat, input bit gaps, input int abort_at, input bit bad);
        int k = 0;
        int cyc = 0;
        int gate_bad = 0;
        bit hs;
        if (abort_at < 0 && !bad) exp_q.push_back(exp_key(pat));
        while (k < N_WORDS && cyc < 2000) begin
            word_data  = word_of(pat, k);
            word_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            load_abort = (abort_at >= 0) && (k == abort_at + 1) && word_valid;
            @(negedge ap_clk);
            if (busy !== 1'b1 || core_start_out !== 1'b0) gate_bad++;
            hs = word_valid && word_ready;
            @(posedge ap_clk); #1;
            if (load_abort && hs) begin
                load_abort = 1'b0;
                word_valid = 1'b0;
                return;
            end
            if (hs) k++;
            cyc++;
        end
        word_valid = 1'b0;
        check("words_accepted", k, N_WORDS);
        check("load_gating", gate_bad, 0);
        if (!gaps) check("gapfree_cycles", cyc, N_WORDS);
`ifdef KEY_CHECKSUM_EN
        word_data  = csum_of(pat) ^ WORD_W'(bad);
        word_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge ap_clk);
            hs = word_ready;
            @(posedge ap_clk); #1;
            cyc++;
        end while (!hs && cyc < 100);
        word_valid = 1'b0;
        check("csum_handshake", hs, 1);
        @(negedge ap_clk);
        check("csum_err", err, bad);
        if (bad) check("csum_key_cleared", key_out == '0, 1);
`else
        @(negedge ap_clk);
`endif
        check("commit_latency", key_valid, !bad);
        check("busy_after", busy, 0);
        word_valid = 1'b1;
        @(negedge ap_clk);
        check("no_extra_word", word_ready, 0);
        @(posedge ap_clk); #1;
        word_valid = 1'b0;
    endtask

    initial begin
        ap_rst_n = 1'b0; load_req = 0; load_abort = 0; core_idle = 0;
        word_valid = 0; word_data = '0; core_start_in = 1'b1;
        #12;
        check("rst_key_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_word_ready", word_ready, 0);
        check("rst_key_zero", key_out == '0, 1);
        check("rst_start_gate", core_start_out, 0);
        @(negedge ap_clk); ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        // counter-pattern load, no gaps
        start_load();
        stream(0, 1'b0, -1, 1'b0);
        check("key_w0", key_out[31:0], 0);
        check("key_w1", key_out[63:32], 1);
        check("key_w95", key_out[3070:3040], 95);
        check("start_pass", core_start_out, 1);

        // load_req under a running core is held off
        load_req = 1'b1; core_idle = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1; @(negedge ap_clk);
        check("held_key_valid", key_valid, 1);
        check("held_busy", busy, 0);
        check("held_key_w1", key_out[63:32], 1);
        core_idle = 1'b1;
        @(posedge ap_clk); #1;
        load_req = 1'b0;
        @(negedge ap_clk);
        check("enter_key_valid", key_valid, 0);
        check("enter_busy", busy, 1);
        @(posedge ap_clk); #1;
        stream(1, 1'b1, -1, 1'b0);
        check("gap_key_w0", key_out[31:0], 32'hA5A5A5A5);
        check("gap_key_w95", key_out[3070:3040], 31'(32'hA5A5A5A5 ^ 32'd95));

        // abort on word 41's handshake, then fresh load
        start_load();
        stream(2, 1'b0, 40, 1'b0);
        @(negedge ap_clk);
        check("abort_busy", busy, 0);
        check("abort_key_valid", key_valid, 0);
        check("abort_key_kept", key_out === exp_key(1), 1);
        @(posedge ap_clk); #1;
        start_load();
        stream(2, 1'b0, -1, 1'b0);

`ifdef KEY_CHECKSUM_EN
        start_load();
        stream(0, 1'b0, -1, 1'b1);
        check("bad_csum_key_valid", key_valid, 0);
`endif

        // asynchronous reset mid-load
        start_load();
        word_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            word_data = word_of(0, k);
            @(posedge ap_clk); #1;
        end
        word_valid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_word_ready", word_ready, 0);
        check("arst_key_valid", key_valid, 0);
        check("arst_err", err, 0);
        check("arst_key_zero", key_out == '0, 1);
        @(negedge ap_clk); ap_rst_n = 1'b1;

        repeat (3) @(negedge ap_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/diff_key_loader.md
Name: diff_key_loader

Overview:
- Upstream stage of the locked `diff` datapath. Receives the 3071-bit working key as a stream of 32-bit words from the on-chip key store.
- Assembles the words in a shadow register and commits the key atomically to the `diff` core's `working_key` input.
- Gates the core's `ap_start` so no computation can begin while the key is absent, partial or invalid.

Parameters:
- KEY_W, 3071, working key width in bits
- WORD_W, 32, key-store word width in bits
- N_WORDS, 96, words per key, equal to ceil(KEY_W/WORD_W)
- CNT_W, 7, width of the word counter, at least clog2(N_WORDS+1)

Ports:
- ap_clk  in  1  clock; all state updates on rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- load_req  in  1  request a new key load; level-sensitive
- load_abort  in  1  abandon an in-progress load
- core_idle  in  1  ap_idle of the `diff` core
- word_valid  in  1  key-store word available
- word_data  in  WORD_W  key-store word
- word_ready  out  1  loader accepts word_data this cycle
- key_out  out  KEY_W  committed working key, to `diff`.working_key
- key_valid  out  1  key_out is complete and committed
- busy  out  1  load in progress
- err  out  1  sticky error flag
- core_start_in  in  1  ap_start from the upstream controller
- core_start_out  out  1  ap_start to `diff`

Behaviour:
- Reset (asynchronous, ap_rst_n=0):
  - key_out=0, shadow=0, key_valid=0, busy=0, err=0, word_ready=0, counter=0, state=IDLE.
- States:
  - IDLE: no key committed.
  - LOAD: accepting words.
  - CHECK: only present with KEY_CHECKSUM_EN.
  - READY: key committed.
- IDLE/READY -> LOAD:
  - Occurs when load_req=1 and core_idle=1.
  - On that edge: key_valid<=0, err<=0, counter<=0, shadow<=0.
  - load_req while core_idle=0 is ignored until core_idle=1. A key is never replaced under a running core.
- LOAD:
  - word_ready=1 and busy=1.
  - A word is accepted on a cycle with word_valid&word_ready.
  - Accepted word k (0-based) is written to shadow bits [WORD_W*k+WORD_W-1 : WORD_W*k]. Bits at or above KEY_W are discarded, so word 95 bit 31 is dropped.
  - counter increments per accepted word. word_valid=0 cycles stall without penalty.
- On acceptance of word N_WORDS-1 (without checksum):
  - Next edge: key_out<=shadow (including the final word), key_valid<=1, busy<=0, word_ready<=0, state=READY.
  - Latency: key_valid high exactly 1 cycle after the last handshake.
- load_abort=1 in LOAD or CHECK:
  - Return to IDLE next edge.
  - Shadow discarded. key_out keeps its previous value; key_valid stays 0.
  - load_abort has priority over a same-cycle word handshake, which is not counted.
- load_req while in LOAD is ignored; the load continues.
- Start gating is combinational: core_start_out = core_start_in & key_valid & ~busy.
- key_out changes only at commit. It never shows a partially loaded key.
- counter saturates logic: no word is accepted beyond N_WORDS (plus 1 with checksum). word_ready drops in the commit cycle.
- Asynchronous reset mid-load aborts immediately to the reset values.

Optional Feature:
- Macro: KEY_CHECKSUM_EN
- Defined:
  - After word N_WORDS-1, state goes to CHECK (word_ready=1) and one further word is accepted as a checksum.
  - Expected checksum: XOR of all N_WORDS raw words, including the dropped bit.
  - Match: commit as above, 1 cycle after the checksum handshake.
  - Mismatch: err<=1, key_out<=0, key_valid<=0, state IDLE.
- Undefined:
  - No CHECK state. err is tied 0. Commit follows the last data word.

Test Plan:
- Reset, then stream words 0..95 with word_data=k (counter value), word_valid held 1 -> 96 handshakes in 96 cycles; key_valid=1 one cycle later; key_out[31:0]=0, key_out[63:32]=1, key_out[3070:3040]=95 (bit 31 of word 95 dropped).
- During load, core_start_in=1 -> core_start_out=0. After commit, core_start_in=1 -> core_start_out=1.
- Random word_valid gaps (50% duty) with pattern 0xA5A5A5A5 ^ k -> final key_out identical to the gap-free run; busy=1 throughout; no extra words accepted.
- load_req with core_idle=0 -> stays READY, key unchanged; raising core_idle=1 -> enters LOAD, key_valid drops the next cycle.
- load_abort after word 40, asserted in the same cycle as a handshake -> IDLE, key_valid=0, key_out equal to the previous committed key; a fresh full load then commits correctly.
- KEY_CHECKSUM_EN: correct XOR word -> commit; checksum XOR 0x1 -> err=1, key_out=0, key_valid=0. Additionally, ap_rst_n pulsed low at word 10 -> all outputs at reset values asynchronously.
